regfile_port_arbiter: RTL
=========================

REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_Nbits, default 5, meaning the register address width.
REQ-002 The block SHALL have parameter DATA_W, default 2**ADDR_Nbits, meaning the write data width.
REQ-003 The block SHALL have port RegisterFile_CLK, input, 1, meaning the clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RegisterFile_RST, input, 1, meaning the reset: asynchronous, active-low.
REQ-005 The block SHALL have ports req0_valid / req1_valid, input, 1 each, meaning requester 0 (ALU writeback) / requester 1 (load writeback) has a write pending.
REQ-006 The block SHALL have ports req0_addr / req1_addr, input, ADDR_Nbits each, meaning the destination register.
REQ-007 The block SHALL have ports req0_data / req1_data, input, DATA_W each, meaning the write data.
REQ-008 The block SHALL have ports req0_ready / req1_ready, output, 1 each, meaning the request is accepted this cycle.
REQ-009 The block SHALL have port clr_start, input, 1, meaning a pulse that requests a zeroing sweep of all registers.
REQ-010 The block SHALL have ports clr_busy, output, 1, meaning a sweep is in progress, and clr_done, output, 1, meaning a one-cycle pulse after the last sweep write.
REQ-011 The block SHALL have ports RegisterFile_WE3, output, 1; RegisterFile_A3, output, ADDR_Nbits; and RegisterFile_WD3, output, DATA_W, meaning the registered write port to the register file.

Function
REQ-012 Handshake: a request SHALL be accepted when reqN_valid and reqN_ready are both high at a rising edge; requesters hold addr/data stable until accepted.
REQ-013 At most one readyN SHALL be high per cycle; readyN is combinational from the valids, the RR pointer, the FSM state and clr_start.
REQ-014 Arbitration SHALL be round-robin: when both are valid, grant the requester not granted most recently; when one is valid, grant it.
REQ-015 The RR pointer SHALL update only on an accepted grant.
REQ-016 Latency: an accepted request SHALL appear on WE3/A3/WD3 exactly one cycle after acceptance; WE3 is high for one cycle per accepted request.
REQ-017 An accepted write to address 0 SHALL be consumed (ready high) and SHALL produce WE3=0 in the following cycle, with A3/WD3 holding their previous values.
REQ-018 The FSM SHALL have states IDLE (no grant last cycle), SERVE (grant issued last cycle) and CLEAR (sweep active).
REQ-019 Transitions: IDLE/SERVE->SERVE on an accepted grant; IDLE/SERVE->IDLE with no grant; IDLE/SERVE->CLEAR on clr_start=1; CLEAR->IDLE after the final sweep write.
REQ-020 clr_start=1 in IDLE/SERVE SHALL force both readyN=0 in that same cycle; clr_start in CLEAR SHALL be ignored.
REQ-021 In CLEAR, a counter SHALL sweep addresses 0..2**ADDR_Nbits-1 with WE3=1 and WD3=0 on each consecutive cycle, for 2**ADDR_Nbits cycles.
REQ-022 clr_busy SHALL be high from the cycle after clr_start through the last sweep write; readyN SHALL stay 0 throughout.
REQ-023 clr_done SHALL pulse high for one cycle in the cycle after the last sweep write, concurrent with the return to IDLE; grants may resume in that cycle.
REQ-024 A write accepted in the same cycle as a prior grant's output (back-to-back) SHALL sustain one write per cycle with no bubble.
REQ-025 Sweep counter wrap SHALL be detected at all-ones; the counter SHALL NOT be read outside CLEAR.

Reset
REQ-026 On RegisterFile_RST=0, asynchronously: state=IDLE, RR pointer favours req0, sweep counter=0, WE3=0, A3=0, WD3=0, clr_busy=0, clr_done=0.
REQ-027 Reset asserted mid-sweep or mid-grant SHALL abort immediately with no further WE3 pulse; an accepted but not yet issued write is dropped.
REQ-028 readyN SHALL be 0 while reset is asserted.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE, SERVE, CLEAR) and the requester index constants (REQ_ALU=0, REQ_LOAD=1).
REQ-030 The round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs: valids, pointer, enable; output: one-hot grant).

Verification
REQ-031 Scenario: req0 only, addr=5, data=0xDEADBEEF -> ready0=1 in cycle 0; WE3=1, A3=5, WD3=0xDEADBEEF in cycle 1.
REQ-032 Scenario: both valid for 4 cycles after reset -> grant order 0,1,0,1; four consecutive WE3 pulses.
REQ-033 Scenario: req1 addr=0, data=0x12 -> ready1=1; WE3=0 in the next cycle.
REQ-034 Scenario: clr_start with req0 valid -> ready0=0; then 32 cycles of WE3=1, A3=0..31, WD3=0; clr_done pulses once; req0 is then accepted.
REQ-035 Scenario: reset pulled low at sweep address 10 -> WE3=0 and clr_busy=0 immediately; after release, state is IDLE and req0 is favoured.
REQ-036 Scenario: clr_start re-pulsed during a sweep -> the sweep length stays 32 and clr_done pulses once.

Source files
------------

// File: rtl/regfile_port_arbiter_pkg.sv
// rtl/regfile_port_arbiter_pkg.sv - shared FSM encoding and requester indices
// Used by the write-port arbiter and its round-robin grant sub-module.
package regfile_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      CLEAR = 2'd2
   } state_t;

   localparam int REQ_ALU  = 0;
   localparam int REQ_LOAD = 1;

endpackage

// File: rtl/regfile_port_arbiter_rr_arbiter2.sv
// rtl/regfile_port_arbiter_rr_arbiter2.sv - two-way round-robin grant logic
// i_ptr names the requester that wins a tie; o_grant is one-hot or zero.
module rr_arbiter2 (
   input  logic [1:0] i_valid,
   input  logic       i_ptr,
   input  logic       i_enable,
   output logic [1:0] o_grant
);

   always_comb begin
      o_grant = 2'b00;
      if (i_enable) begin
         if (i_valid == 2'b11) begin
            o_grant = i_ptr ? 2'b10 : 2'b01;
         end else begin
            o_grant = i_valid;
         end
      end
   end

endmodule

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - arbitrates two writeback requesters onto port 3
// Also runs a zeroing sweep over every register on clr_start.
module regfile_port_arbiter
   import regfile_port_arbiter_pkg::*;
#(
   parameter int ADDR_Nbits = 5,
   parameter int DATA_W     = 2**ADDR_Nbits
) (
   input  logic                  RegisterFile_CLK,
   input  logic                  RegisterFile_RST,
   input  logic                  req0_valid,
   input  logic [ADDR_Nbits-1:0] req0_addr,
   input  logic [DATA_W-1:0]     req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [ADDR_Nbits-1:0] req1_addr,
   input  logic [DATA_W-1:0]     req1_data,
   output logic                  req1_ready,
   input  logic                  clr_start,
   output logic                  clr_busy,
   output logic                  clr_done,
   output logic                  RegisterFile_WE3,
   output logic [ADDR_Nbits-1:0] RegisterFile_A3,
   output logic [DATA_W-1:0]     RegisterFile_WD3
);

   state_t                  r_state, w_state_nxt;
   logic                    r_ptr, w_ptr_nxt;
   logic [ADDR_Nbits-1:0]   r_cnt, w_cnt_nxt;
   logic                    r_we, w_we_nxt;
   logic [ADDR_Nbits-1:0]   r_a3, w_a3_nxt;
   logic [DATA_W-1:0]       r_wd, w_wd_nxt;
   logic                    r_busy, w_busy_nxt;
   logic                    r_done, w_done_nxt;

   logic                    w_enable;
   logic [1:0]              w_grant;
   logic                    w_acc;
   logic                    w_sel;
   logic [ADDR_Nbits-1:0]   w_addr;
   logic [DATA_W-1:0]       w_data;

   // Grants are suppressed while in reset, sweeping, or about to sweep.
   assign w_enable = RegisterFile_RST && (r_state != CLEAR) && !clr_start;

   rr_arbiter2 u_rr_arbiter2 (
      .i_valid  ({req1_valid, req0_valid}),
      .i_ptr    (r_ptr),
      .i_enable (w_enable),
      .o_grant  (w_grant)
   );

   assign req0_ready = w_grant[REQ_ALU];
   assign req1_ready = w_grant[REQ_LOAD];
   assign w_acc      = |w_grant;
   assign w_sel      = w_grant[REQ_LOAD];
   assign w_addr     = w_sel ? req1_addr : req0_addr;
   assign w_data     = w_sel ? req1_data : req0_data;

   always_ff @(posedge RegisterFile_CLK or negedge RegisterFile_RST) begin
      if (!RegisterFile_RST) begin
         r_state <= IDLE;
         r_ptr   <= 1'b0;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_a3    <= '0;
         r_wd    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_we    <= w_we_nxt;
         r_a3    <= w_a3_nxt;
         r_wd    <= w_wd_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      w_we_nxt    = 1'b0;
      w_a3_nxt    = r_a3;
      w_wd_nxt    = r_wd;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      unique case (r_state)
         IDLE, SERVE: begin
            if (clr_start) begin
               // Address 0 goes out on the very next cycle so the sweep fills the busy window.
               w_state_nxt = CLEAR;
               w_cnt_nxt   = '0;
               w_we_nxt    = 1'b1;
               w_a3_nxt    = '0;
               w_wd_nxt    = '0;
               w_busy_nxt  = 1'b1;
            end else if (w_acc) begin
               w_state_nxt = SERVE;
               w_ptr_nxt   = !w_sel;
               if (w_addr != '0) begin
                  w_we_nxt = 1'b1;
                  w_a3_nxt = w_addr;
                  w_wd_nxt = w_data;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         CLEAR: begin
            if (r_cnt == '1) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
               w_we_nxt  = 1'b1;
               w_a3_nxt  = r_cnt + 1'b1;
               w_wd_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign RegisterFile_WE3 = r_we;
   assign RegisterFile_A3  = r_a3;
   assign RegisterFile_WD3 = r_wd;
   assign clr_busy         = r_busy;
   assign clr_done         = r_done;

endmodule
